// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - register map, bit indices and TX FSM states for uart_ctrl
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_TX_BUSY  = 5;

    // STATUS write-one-to-clear positions for the sticky flags
    localparam int CLR_TX_OVF = 2;
    localparam int CLR_RX_OVR = 3;

    localparam int CTRL_RX_EN     = 0;
    localparam int CTRL_RX_IRQ_EN = 1;
    localparam int CTRL_TX_IRQ_EN = 2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// rtl/uart_ctrl_fifo.sv - synchronous FIFO; a push while full is accepted when a pop occurs in the same cycle
module uart_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - CPU-facing UART sequencer; UART_CTRL_RX_FIFO_EN selects an RX FIFO over a holding register
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int TX_DEPTH     = 8,
    parameter int RX_DEPTH     = 4,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [1:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_enable,
    input  logic       uart_tx_status,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_status,
    output logic       uart_rx_enable
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
        $error("TX_DEPTH must be a power of two >= 2");
    end
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
        $error("RX_DEPTH must be a power of two >= 2");
    end

    logic       wr_txdata, wr_status, wr_ctrl, rd_rxdata;
    logic [2:0] ctrl;
    logic       tx_ovf, rx_ovr;
    logic [7:0] status;

    assign wr_txdata      = bus_wr & (bus_addr == ADDR_TXDATA);
    assign wr_status      = bus_wr & (bus_addr == ADDR_STATUS);
    assign wr_ctrl        = bus_wr & (bus_addr == ADDR_CTRL);
    assign rd_rxdata      = bus_rd & (bus_addr == ADDR_RXDATA);
    assign uart_rx_enable = ctrl[CTRL_RX_EN];

    // TX path
    tx_state_t   state, state_nxt;
    logic        tx_pop, tx_tmo, tx_full, tx_empty, tx_busy;
    logic [7:0]  tx_head;
    logic [TW-1:0] tmo_cnt;

    uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .push    (wr_txdata),
        .pop     (tx_pop),
        .din     (bus_wdata),
        .dout    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign tx_busy        = (state != IDLE);
    assign uart_tx_enable = (state == LAUNCH);

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        tx_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && uart_tx_status) begin
                    tx_pop    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!uart_tx_status) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TW'(BUSY_TIMEOUT)) begin
                    tx_tmo    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (uart_tx_status) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            uart_tx_data <= 8'h00;
            tmo_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (tx_pop) uart_tx_data <= tx_head;
            if (state == LAUNCH)         tmo_cnt <= '0;
            else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // RX path: uart_rx_status is on the baud clock, so resynchronise before edge detect
    logic [2:0] rx_sync;
    logic       rx_push, rx_pop, rx_valid, rx_full;
    logic [7:0] rx_head;

    assign rx_push = rx_sync[1] & ~rx_sync[2] & ctrl[CTRL_RX_EN];
    assign rx_pop  = rd_rxdata & rx_valid;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) rx_sync <= 3'b000;
        else          rx_sync <= {rx_sync[1:0], uart_rx_status};
    end

`ifdef UART_CTRL_RX_FIFO_EN
    logic rx_empty;

    uart_ctrl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .din     (uart_rx_data),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign rx_valid = ~rx_empty;
`else
    logic       rx_hold_valid;
    logic [7:0] rx_hold_data;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_hold_valid <= 1'b0;
            rx_hold_data  <= 8'h00;
        end else if (rx_push && (!rx_hold_valid || rx_pop)) begin
            rx_hold_valid <= 1'b1;
            rx_hold_data  <= uart_rx_data;
        end else if (rx_pop) begin
            rx_hold_valid <= 1'b0;
        end
    end

    assign rx_valid = rx_hold_valid;
    assign rx_full  = rx_hold_valid;
    assign rx_head  = rx_hold_data;
`endif

    // Registers, sticky flags (a new set beats a same-cycle clear), read data, irq
    always_comb begin
        status              = 8'h00;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_TX_BUSY]  = tx_busy;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl      <= 3'b000;
            tx_ovf    <= 1'b0;
            rx_ovr    <= 1'b0;
            bus_rdata <= 8'h00;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus_wdata[2:0];

            if ((wr_txdata && tx_full && !tx_pop) || tx_tmo)  tx_ovf <= 1'b1;
            else if (wr_status && bus_wdata[CLR_TX_OVF])      tx_ovf <= 1'b0;

            if (rx_push && rx_full && !rx_pop)                rx_ovr <= 1'b1;
            else if (wr_status && bus_wdata[CLR_RX_OVR])      rx_ovr <= 1'b0;

            if (bus_rd) begin
                case (bus_addr)
                    ADDR_RXDATA: bus_rdata <= rx_valid ? rx_head : 8'h00;
                    ADDR_STATUS: bus_rdata <= status;
                    ADDR_CTRL:   bus_rdata <= {5'b00000, ctrl};
                    default:     bus_rdata <= 8'h00;
                endcase
            end

            irq <= (ctrl[CTRL_RX_IRQ_EN] & rx_valid) |
                   (ctrl[CTRL_TX_IRQ_EN] & tx_empty & ~tx_busy);
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - directed-vector bench for uart_ctrl (adapts RX capacity to UART_CTRL_RX_FIFO_EN)
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    localparam int BUSY_TIMEOUT = 1023;
`ifdef UART_CTRL_RX_FIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic       bus_wr = 1'b0;
    logic       bus_rd = 1'b0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       irq;
    logic [7:0] uart_tx_data;
    logic       uart_tx_enable;
    logic       uart_tx_status = 1'b1;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_status = 1'b0;
    logic       uart_rx_enable;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 sysclk = ~sysclk;

    uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(4), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .sysclk         (sysclk),
        .reset_n        (reset_n),
        .bus_addr       (bus_addr),
        .bus_wr         (bus_wr),
        .bus_rd         (bus_rd),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .irq            (irq),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_enable (uart_tx_enable),
        .uart_tx_status (uart_tx_status),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_status (uart_rx_status),
        .uart_rx_enable (uart_rx_enable)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        tick();
        bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_rd   = 1'b1;
        tick();
        bus_rd   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic wait_launch(input string tag, output logic [7:0] d);
        int n = 0;
        while (uart_tx_enable !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (uart_tx_enable !== 1'b1) chk({tag, "_no_launch"}, 8'(uart_tx_enable), 8'h01);
        d = uart_tx_data;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input int hi);
        uart_rx_data   = d;
        uart_rx_status = 1'b1;
        repeat (hi) tick();
        uart_rx_status = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] d;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_rdata", bus_rdata, 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_tx_data", uart_tx_data, 8'h00);
        chk("rst_tx_en", 8'(uart_tx_enable), 8'h00);
        chk("rst_rx_en", 8'(uart_rx_enable), 8'h00);
        bus_read(ADDR_STATUS, rd); chk("rst_status", rd, 8'h02);
        bus_read(ADDR_CTRL, rd);   chk("rst_ctrl", rd, 8'h00);
        bus_read(ADDR_RXDATA, rd); chk("rst_rxdata", rd, 8'h00);
        bus_read(ADDR_TXDATA, rd); chk("txdata_read", rd, 8'h00);

        // Single byte: enable pulse exactly in cycle N+2
        bus_write(ADDR_TXDATA, 8'h55);
        chk("single_en_n1", 8'(uart_tx_enable), 8'h00);
        tick();
        chk("single_en_n2", 8'(uart_tx_enable), 8'h01);
        chk("single_data", uart_tx_data, 8'h55);
        uart_tx_status = 1'b0;
        tick();
        chk("single_en_n3", 8'(uart_tx_enable), 8'h00);
        repeat (300) tick();
        bus_read(ADDR_STATUS, rd); chk("single_busy", rd, 8'h22);
        uart_tx_status = 1'b1;
        tick();
        bus_read(ADDR_STATUS, rd); chk("single_idle", rd, 8'h02);
        chk("single_data_hold", uart_tx_data, 8'h55);

        // TX full and overflow, then in-order drain
        uart_tx_status = 1'b0;
        for (int i = 1; i <= 9; i++) bus_write(ADDR_TXDATA, 8'(i));
        bus_read(ADDR_STATUS, rd); chk("txfull_status", rd, 8'h0C);
        uart_tx_status = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_launch($sformatf("txfull_%0d", i), d);
            chk($sformatf("txfull_byte%0d", i), d, 8'(i + 1));
            uart_tx_status = 1'b0;
            repeat (3) tick();
            uart_tx_status = 1'b1;
        end
        repeat (2) tick();
        bus_read(ADDR_STATUS, rd); chk("txfull_drained", rd, 8'h0A);
        bus_write(ADDR_STATUS, 8'h04);
        bus_read(ADDR_STATUS, rd); chk("txovf_clear", rd, 8'h02);

        // TX-empty interrupt
        bus_write(ADDR_CTRL, 8'h04);
        repeat (2) tick();
        chk("tx_irq", 8'(irq), 8'h01);
        bus_write(ADDR_CTRL, 8'h00);
        repeat (2) tick();
        chk("tx_irq_off", 8'(irq), 8'h00);

        // RX capture with interrupt
        bus_write(ADDR_CTRL, 8'h03);
        chk("rx_en_out", 8'(uart_rx_enable), 8'h01);
        rx_pulse(8'hA7, 326);
        chk("rx_irq_rise", 8'(irq), 8'h01);
        bus_read(ADDR_STATUS, rd); chk("rx_status", rd, 8'h03);
        bus_read(ADDR_RXDATA, rd); chk("rx_data", rd, 8'hA7);
        tick();
        chk("rx_irq_fall", 8'(irq), 8'h00);
        bus_read(ADDR_RXDATA, rd); chk("rx_empty_read", rd, 8'h00);

        // RX disabled: pulse ignored
        bus_write(ADDR_CTRL, 8'h00);
        rx_pulse(8'hEE, 30);
        bus_read(ADDR_STATUS, rd); chk("rx_disabled", rd, 8'h02);

        // RX overrun
        bus_write(ADDR_CTRL, 8'h01);
        for (int i = 0; i <= RX_CAP; i++) rx_pulse(8'(8'h10 + i), 20);
        bus_read(ADDR_STATUS, rd); chk("rxovr_status", rd, 8'h13);
        for (int i = 0; i < RX_CAP; i++) begin
            bus_read(ADDR_RXDATA, rd);
            chk($sformatf("rxovr_byte%0d", i), rd, 8'(8'h10 + i));
        end
        bus_read(ADDR_STATUS, rd); chk("rxovr_drained", rd, 8'h12);
        bus_write(ADDR_STATUS, 8'h08);
        bus_read(ADDR_STATUS, rd); chk("rxovr_clear", rd, 8'h02);

        // Busy timeout with status stuck idle
        uart_tx_status = 1'b1;
        bus_write(ADDR_TXDATA, 8'h3C);
        wait_launch("tmo", d);
        chk("tmo_data", d, 8'h3C);
        repeat (1000) tick();
        bus_read(ADDR_STATUS, rd); chk("tmo_waiting", rd, 8'h22);
        repeat (40) tick();
        bus_read(ADDR_STATUS, rd); chk("tmo_expired", rd, 8'h0A);
        bus_write(ADDR_STATUS, 8'h04);

        // Asynchronous reset in WAIT_DONE
        bus_write(ADDR_CTRL, 8'h03);
        rx_pulse(8'h5A, 20);
        bus_write(ADDR_TXDATA, 8'h99);
        wait_launch("mid", d);
        chk("mid_data", d, 8'h99);
        uart_tx_status = 1'b0;
        repeat (3) tick();
        bus_write(ADDR_TXDATA, 8'h77);
        bus_read(ADDR_CTRL, rd); chk("mid_ctrl", rd, 8'h03);
        chk("mid_irq", 8'(irq), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rdata", bus_rdata, 8'h00);
        chk("arst_irq", 8'(irq), 8'h00);
        chk("arst_tx_data", uart_tx_data, 8'h00);
        chk("arst_tx_en", 8'(uart_tx_enable), 8'h00);
        chk("arst_rx_en", 8'(uart_rx_enable), 8'h00);
        uart_tx_status = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        bus_read(ADDR_STATUS, rd); chk("arst_status", rd, 8'h02);
        bus_read(ADDR_RXDATA, rd); chk("arst_rxdata", rd, 8'h00);
        repeat (5) tick();
        bus_read(ADDR_STATUS, rd); chk("arst_no_launch", rd, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
